// File: rtl/bfp_dot_stream.sv
// bfp_dot_stream
// ---------------------------------------------------------------------------
// Streaming block-floating-point dot-product engine. Two BFP vectors of V
// elements arrive as P-lane mantissa beats, each vector with one shared
// exponent. Lanes are multiplied (signed), reduced through a binary adder
// tree, and the tree outputs of the NB = V/P beats are accumulated into one
// signed sum with the exponent sum alongside.
//
// Optional feature macro: BFP_DOT_NORM_EN
//   defined   : one extra output stage left-normalises the sum (removes
//               redundant sign bits) and lowers the exponent to match.
//   undefined : the raw accumulator and the raw exponent sum are output.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high
//   in_valid   beat valid
//   in_ready   beat accepted when in_valid & in_ready at a clock edge
//   in_a/in_b  P lane mantissas, lane k at [k*MW +: MW], two's complement
//   in_exp_a/b shared exponents, sampled on the first beat of a vector
//   in_last    marks the final beat of a vector
//   out_valid  result valid, held until out_ready
//   out_ready  result consumed when out_valid & out_ready
//   out_sum    signed dot product (SW bits)
//   out_exp    signed result exponent (EW+2 bits)
//   out_err    framing error: in_last and the beat count disagreed
// ---------------------------------------------------------------------------
module bfp_dot_stream #(
    parameter int V        = 64,
    parameter int P        = 8,
    parameter int BFPM     = 7,
    parameter int EW       = 8,
    parameter int TREE_REG = 1,
    localparam int MW  = BFPM + 2,
    localparam int SW  = 2 * MW + $clog2(V),
    localparam int NB  = V / P,
    localparam int L   = $clog2(P),
    localparam int TW  = 2 * MW + L,
    localparam int CW  = (NB > 1) ? $clog2(NB) : 1,
    localparam int XW  = EW + 2,
    localparam int TL  = (TREE_REG != 0) ? L : 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [P*MW-1:0]      in_a,
    input  logic [P*MW-1:0]      in_b,
    input  logic [EW-1:0]        in_exp_a,
    input  logic [EW-1:0]        in_exp_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [SW-1:0] out_sum,
    output logic [XW-1:0]        out_exp,
    output logic                 out_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                state_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;
    logic                  out_err_reg;
    logic                  err_reg;
    logic [CW-1:0]         cnt_reg;
    logic [XW-1:0]         exp_reg;
    logic signed [SW-1:0]  acc_reg;

    // ------------------------------------------------------------------
    // Beat acceptance and framing
    // ------------------------------------------------------------------
    logic accept;
    logic at_end;
    logic closing;
    logic framing_err;
    logic is_first;

    assign accept      = in_valid & in_ready_reg;
    assign at_end      = (cnt_reg == CW'(NB - 1));
    // A vector closes on whichever comes first: in_last or the final count.
    assign closing     = in_last | at_end;
    assign framing_err = in_last ^ at_end;
    assign is_first    = (cnt_reg == '0);

    // ------------------------------------------------------------------
    // Tag pipeline: valid/first/last travel alongside the data so the
    // accumulator knows when to load and the FSM knows when to close.
    // Stage 0 is the product register, stages 1..TL the tree layers.
    // ------------------------------------------------------------------
    logic [TL:0] v_pipe;
    logic [TL:0] first_pipe;
    logic [TL:0] last_pipe;

    generate
        if (TREE_REG != 0) begin : g_tag_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_pipe     <= '0;
                    first_pipe <= '0;
                    last_pipe  <= '0;
                end else begin
                    v_pipe     <= {v_pipe[TL-1:0], accept};
                    first_pipe <= {first_pipe[TL-1:0], accept & is_first};
                    last_pipe  <= {last_pipe[TL-1:0], accept & closing};
                end
            end
        end else begin : g_tag_comb
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_pipe     <= '0;
                    first_pipe <= '0;
                    last_pipe  <= '0;
                end else begin
                    v_pipe     <= accept;
                    first_pipe <= accept & is_first;
                    last_pipe  <= accept & closing;
                end
            end
        end
    endgenerate

    logic v_out;
    logic first_out;
    logic last_out;

    assign v_out     = v_pipe[TL];
    assign first_out = first_pipe[TL];
    assign last_out  = last_pipe[TL];

    // ------------------------------------------------------------------
    // Products and adder tree, heap-indexed: leaves at P..2P-1, node i is
    // the sum of nodes 2i and 2i+1, root at 1. Every node is carried at
    // the final tree width so each layer's one-bit growth is implicit.
    // ------------------------------------------------------------------
    logic signed [TW-1:0] tree [1:2*P-1];

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_lane
            logic signed [MW-1:0]   a_l;
            logic signed [MW-1:0]   b_l;
            logic signed [2*MW-1:0] prod_reg;

            assign a_l = in_a[gi*MW +: MW];
            assign b_l = in_b[gi*MW +: MW];

            always_ff @(posedge clk) begin
                prod_reg <= (2*MW)'(a_l) * (2*MW)'(b_l);
            end

            assign tree[P+gi] = TW'(prod_reg);
        end

        for (gi = 1; gi < P; gi++) begin : g_node
            if (TREE_REG != 0) begin : g_reg
                logic signed [TW-1:0] node_reg;
                always_ff @(posedge clk) begin
                    node_reg <= tree[2*gi] + tree[2*gi+1];
                end
                assign tree[gi] = node_reg;
            end else begin : g_comb
                assign tree[gi] = tree[2*gi] + tree[2*gi+1];
            end
        end
    endgenerate

    logic signed [SW-1:0] tree_ext;
    assign tree_ext = SW'(tree[1]);

    // ------------------------------------------------------------------
    // Accumulator: first beat of a vector loads, later beats add.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (v_out) begin
            acc_reg <= first_out ? tree_ext : acc_reg + tree_ext;
        end
    end

`ifdef BFP_DOT_NORM_EN
    // ------------------------------------------------------------------
    // Normaliser: count redundant sign bits below the MSB, capped so an
    // all-ones value still leaves a sign bit and one data bit.
    // ------------------------------------------------------------------
    localparam int SHW = $clog2(SW);

    logic                 close_reg;
    logic [SHW-1:0]       norm_shift;
    logic                 norm_found;
    logic signed [SW-1:0] out_sum_reg;
    logic [XW-1:0]        out_exp_reg;

    always_comb begin
        norm_shift = '0;
        norm_found = 1'b0;
        for (int i = SW - 2; i >= 0; i--) begin
            if (!norm_found) begin
                if (acc_reg[i] == acc_reg[SW-1]) begin
                    norm_shift = norm_shift + SHW'(1);
                end else begin
                    norm_found = 1'b1;
                end
            end
        end
        if (norm_shift > SHW'(SW - 2)) begin
            norm_shift = SHW'(SW - 2);
        end
        if (acc_reg == '0) begin
            norm_shift = '0;
        end
    end

    assign out_sum = out_sum_reg;
    assign out_exp = out_exp_reg;
`else
    assign out_sum = acc_reg;
    assign out_exp = exp_reg;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_err_reg   <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            exp_reg       <= '0;
`ifdef BFP_DOT_NORM_EN
            close_reg     <= 1'b0;
            out_sum_reg   <= '0;
            out_exp_reg   <= '0;
`endif
        end else begin
`ifdef BFP_DOT_NORM_EN
            close_reg <= v_out & last_out;
`endif
            case (state_reg)
                S_IDLE, S_ACCUM: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        if (is_first) begin
                            exp_reg <= XW'(in_exp_a) + XW'(in_exp_b);
                        end
                        if (closing) begin
                            cnt_reg      <= '0;
                            err_reg      <= framing_err;
                            in_ready_reg <= 1'b0;
                            state_reg    <= S_DRAIN;
                        end else begin
                            cnt_reg   <= cnt_reg + CW'(1);
                            state_reg <= S_ACCUM;
                        end
                    end
                end
                S_DRAIN: begin
`ifdef BFP_DOT_NORM_EN
                    // Accumulator settled on the previous edge; normalise it.
                    if (close_reg) begin
                        out_sum_reg   <= acc_reg <<< norm_shift;
                        out_exp_reg   <= exp_reg - XW'(norm_shift);
                        out_err_reg   <= err_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_OUT;
                    end
`else
                    // Closing beat reaches the accumulator on this edge.
                    if (v_out && last_out) begin
                        out_err_reg   <= err_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_OUT;
                    end
`endif
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_err_reg   <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_err   = out_err_reg;

endmodule

// File: tb/tb_bfp_dot_stream.sv
// tb_bfp_dot_stream
// Directed-vector bench for bfp_dot_stream with V=16, P=4, BFPM=6, EW=5,
// TREE_REG=1 (MW=8, SW=20, D=3). Expected values are hand-computed; the
// BFP_DOT_NORM_EN build selects the normalised expectations.
module tb_bfp_dot_stream;

    localparam int V        = 16;
    localparam int P        = 4;
    localparam int BFPM     = 6;
    localparam int EW       = 5;
    localparam int TREE_REG = 1;
    localparam int MW       = 8;
    localparam int SW       = 20;
    localparam int XW       = 7;
`ifdef BFP_DOT_NORM_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [P*MW-1:0] in_a;
    logic [P*MW-1:0] in_b;
    logic [EW-1:0]   in_exp_a;
    logic [EW-1:0]   in_exp_b;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_sum;
    logic [XW-1:0]   out_exp;
    logic            out_err;

    bfp_dot_stream #(
        .V(V), .P(P), .BFPM(BFPM), .EW(EW), .TREE_REG(TREE_REG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_exp_a(in_exp_a),
        .in_exp_b(in_exp_b),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_exp(out_exp),
        .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int test_count = 0;
    int fail_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        test_count++;
        if (got !== want) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [P*MW-1:0] rep(input int v);
        logic [MW-1:0] b;
        b = MW'(v);
        return {P{b}};
    endfunction

    // Sends nbeats back-to-back; in_last on beat last_at (1-based, 0 = none).
    task automatic send_vec(input int nbeats, input int last_at,
                            input logic [P*MW-1:0] a, input logic [P*MW-1:0] b,
                            input logic [EW-1:0] ea, input logic [EW-1:0] eb);
        int guard;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            in_exp_a = ea;
            in_exp_b = eb;
            in_last  = ((i + 1) == last_at);
            guard = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) check("beat_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called on the negedge right after the closing edge; checks latency.
    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
    endtask

    task automatic take_result(input string tag, input logic [SW-1:0] want_sum,
                               input logic [XW-1:0] want_exp, input logic want_err);
        $display("[TB] %s: sum=0x%05h exp=0x%02h err=%0b", tag, out_sum, out_exp, out_err);
        check({tag, "_sum"}, 32'(out_sum), 32'(want_sum));
        check({tag, "_exp"}, 32'(out_exp), 32'(want_exp));
        check({tag, "_err"}, 32'(out_err), 32'(want_err));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        check({tag, "_out_exp"}, 32'(out_exp), 32'd0);
        check({tag, "_out_err"}, 32'(out_err), 32'd0);
    endtask

    // Expected results per case
    logic [SW-1:0] e1_sum, e2_sum, e3_sum, e4_sum, e5_sum, e6_sum;
    logic [XW-1:0] e1_exp, e2_exp, e3_exp, e4_exp, e5_exp, e6_exp;
    logic [P*MW-1:0] mix_a, mix_b;
    logic [SW-1:0] held_sum;

    initial begin
`ifdef BFP_DOT_NORM_EN
        e1_sum = 20'h40000; e1_exp = 7'd5;     // 0x10000, s=2
        e2_sum = 20'h80000; e2_exp = 7'd4;     // 0xF0000, s=3
        e3_sum = 20'h40000; e3_exp = 7'd4;     // 0x08000, s=3
        e4_sum = 20'h40000; e4_exp = 7'd5;     // 0x10000, s=2
        e5_sum = 20'h9C000; e5_exp = 7'h79;    // -400, s=10, exp 3-10
        e6_sum = 20'h40000; e6_exp = 7'h72;    // 4, s=16, exp 2-16
`else
        e1_sum = 20'h10000; e1_exp = 7'd7;
        e2_sum = 20'hF0000; e2_exp = 7'd7;
        e3_sum = 20'h08000; e3_exp = 7'd7;
        e4_sum = 20'h10000; e4_exp = 7'd7;
        e5_sum = 20'hFFE70; e5_exp = 7'd3;
        e6_sum = 20'h00004; e6_exp = 7'd2;
`endif
        // lanes a = {10,-20,30,-40}, b = {1,2,3,4}: -100 per beat
        mix_a = {8'hD8, 8'h1E, 8'hEC, 8'h0A};
        mix_b = {8'h04, 8'h03, 8'h02, 8'h01};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_exp_a  = '0;
        in_exp_b  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("por_ready_after", 32'(in_ready), 32'd1);

        // Basic: all 64*64, closing with in_last on beat 4
        send_vec(4, 4, rep(64), rep(64), 5'd3, 5'd4);
        wait_result("basic");
        take_result("basic", e1_sum, e1_exp, 1'b0);

        // Negative operand
        send_vec(4, 4, rep(-64), rep(64), 5'd3, 5'd4);
        wait_result("neg");
        take_result("neg", e2_sum, e2_exp, 1'b0);

        // Early last on beat 2: partial sum, error flagged
        send_vec(2, 2, rep(64), rep(64), 5'd3, 5'd4);
        wait_result("early");
        take_result("early", e3_sum, e3_exp, 1'b1);

        // Missing last: closes on the count, error flagged
        send_vec(4, 0, rep(64), rep(64), 5'd3, 5'd4);
        wait_result("nolast");
        take_result("nolast", e4_sum, e4_exp, 1'b1);

        // Lane-distinct operands
        send_vec(4, 4, mix_a, mix_b, 5'd2, 5'd1);
        wait_result("mixed");
        take_result("mixed", e5_sum, e5_exp, 1'b0);

        // All-zero mantissas
        send_vec(4, 4, rep(0), rep(0), 5'd3, 5'd4);
        wait_result("zero");
        take_result("zero", 20'h00000, 7'd7, 1'b0);

        // Back-pressure: result held, a pending beat must wait
        send_vec(4, 4, rep(64), rep(64), 5'd3, 5'd4);
        wait_result("stall");
        held_sum = out_sum;
        in_valid = 1'b1;
        in_a     = rep(1);
        in_b     = rep(1);
        in_exp_a = 5'd1;
        in_exp_b = 5'd1;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(out_sum), 32'(e1_sum));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        check("stall_sum_hold", 32'(out_sum), 32'(held_sum));
        take_result("stall", e1_sum, e1_exp, 1'b0);
        // the held beat is accepted on the edge after the handshake
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_result("held");
        take_result("held", e6_sum, e6_exp, 1'b1);

        // Reset mid-vector, then a clean vector with no residue
        send_vec(2, 0, rep(100), rep(100), 5'd1, 5'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        send_vec(4, 4, rep(64), rep(64), 5'd3, 5'd4);
        wait_result("postrst");
        take_result("postrst", e1_sum, e1_exp, 1'b0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", test_count);
        $fatal(1, "watchdog");
    end

endmodule
